// File: rtl/bc_pkg.sv
// Shared types and display constants for the two-player bulls-and-cows engine.
package bc_pkg;

  typedef enum logic [2:0] {
    SECRET_J1,
    SECRET_J2,
    GUESS_J1,
    RESULT_J1,
    GUESS_J2,
    RESULT_J2,
    WIN,
    DRAW
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_J1   = 2'd1;
  localparam logic [1:0] WIN_J2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  // Letters keep bit5 and bit0 set so they can never collide with a numeric code.
  localparam logic [5:0] CH_BLANK = 6'b100000;
  localparam logic [5:0] CH_B     = 6'h21;
  localparam logic [5:0] CH_C     = 6'h23;
  localparam logic [5:0] CH_S     = 6'h25;
  localparam logic [5:0] CH_E     = 6'h27;
  localparam logic [5:0] CH_G     = 6'h29;
  localparam logic [5:0] CH_U     = 6'h2B;
  localparam logic [5:0] CH_J     = 6'h2D;
  localparam logic [5:0] CH_D     = 6'h31;
  localparam logic [5:0] CH_R     = 6'h33;
  localparam logic [5:0] CH_A     = 6'h35;
  localparam logic [5:0] CH_W     = 6'h37;
  localparam logic [5:0] CH_I     = 6'h39;
  localparam logic [5:0] CH_N     = 6'h3B;
  localparam logic [5:0] CH_T     = 6'h3D;
  localparam logic [5:0] CH_1     = 6'b000010;
  localparam logic [5:0] CH_2     = 6'b000100;

  // The leftmost element of each concatenation is char7.
  localparam logic [47:0] TXT_BLANK     = {8{CH_BLANK}};
  localparam logic [47:0] TXT_SECRET_J1 = {CH_S, CH_E, CH_C, CH_BLANK, CH_J, CH_1, CH_BLANK, CH_BLANK};
  localparam logic [47:0] TXT_SECRET_J2 = {CH_S, CH_E, CH_C, CH_BLANK, CH_J, CH_2, CH_BLANK, CH_BLANK};
  localparam logic [47:0] TXT_GUESS_J1  = {CH_G, CH_U, CH_E, CH_S, CH_BLANK, CH_J, CH_1, CH_BLANK};
  localparam logic [47:0] TXT_GUESS_J2  = {CH_G, CH_U, CH_E, CH_S, CH_BLANK, CH_J, CH_2, CH_BLANK};
  localparam logic [47:0] TXT_RESULT_J1 = {CH_BLANK, CH_T, CH_1, CH_BLANK, CH_C, CH_BLANK, CH_B, CH_BLANK};
  localparam logic [47:0] TXT_RESULT_J2 = {CH_BLANK, CH_T, CH_2, CH_BLANK, CH_C, CH_BLANK, CH_B, CH_BLANK};
  localparam logic [47:0] TXT_WIN       = {CH_BLANK, CH_J, CH_BLANK, CH_W, CH_I, CH_N, CH_BLANK, CH_BLANK};
  localparam logic [47:0] TXT_DRAW      = {CH_D, CH_R, CH_A, CH_W, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};

  function automatic logic [5:0] num_char(input logic [3:0] value);
    return {1'b0, value, 1'b0};
  endfunction

  function automatic logic [5:0] blank_char();
    return CH_BLANK;
  endfunction

endpackage

// File: rtl/bc_scorer.sv
// Combinational scoring of a guess against a secret, plus entry validity
// (every digit in range and all digits pairwise distinct).
module bc_scorer #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_MAX = 9
) (
  input  logic [DIGITS*4-1:0] guess,
  input  logic [DIGITS*4-1:0] secret,
  output logic [2:0]          bulls,
  output logic [2:0]          cows,
  output logic                valid
);

  localparam logic [3:0] DMAX = 4'(DIGIT_MAX);

  // Cows may wrap on an invalid entry; such results are never registered.
  always_comb begin
    bulls = '0;
    cows  = '0;
    valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (guess[4*i +: 4] > DMAX) valid = 1'b0;
      if (guess[4*i +: 4] == secret[4*i +: 4]) bulls = bulls + 3'd1;
      for (int j = 0; j < DIGITS; j++) begin
        if (i != j) begin
          if (guess[4*i +: 4] == guess[4*j +: 4]) valid = 1'b0;
          if (guess[4*i +: 4] == secret[4*j +: 4]) cows = cows + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bulls_cows_engine.sv
// Two-player bulls-and-cows game controller: secret entry, alternating
// scored guesses, win/draw detection and an eight-character text display.
module bulls_cows_engine
  import bc_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DIGIT_MAX = 9,
  parameter int MAX_TRIES = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                confirm,
  input  logic [DIGITS*4-1:0] sw,
  output logic [47:0]         disp,
  output logic [2:0]          bulls,
  output logic [2:0]          cows,
  output logic [3:0]          tries_j1,
  output logic [3:0]          tries_j2,
  output logic [1:0]          winner,
  output logic                err
);

  localparam logic [2:0] FULL  = 3'(DIGITS);
  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

  state_t state, next_state;

  logic                confirm_prev;
  logic                tick;
  logic [DIGITS*4-1:0] secret_1;
  logic [DIGITS*4-1:0] secret_2;
  logic [DIGITS*4-1:0] opponent_secret;
  logic [2:0]          sc_bulls;
  logic [2:0]          sc_cows;
  logic                sc_valid;

  logic                store_s1;
  logic                store_s2;
  logic                do_score;
  logic                do_clear;
  logic                set_winner;
  logic [1:0]          winner_next;
  logic                err_next;
  logic [47:0]         disp_next;

  assign opponent_secret = (state == GUESS_J2) ? secret_1 : secret_2;

  bc_scorer #(
    .DIGITS   (DIGITS),
    .DIGIT_MAX(DIGIT_MAX)
  ) u_scorer (
    .guess (sw),
    .secret(opponent_secret),
    .bulls (sc_bulls),
    .cows  (sc_cows),
    .valid (sc_valid)
  );

  // Edge register starts high so a button held through reset is ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      confirm_prev <= 1'b1;
      tick         <= 1'b0;
    end else begin
      confirm_prev <= confirm;
      tick         <= confirm & ~confirm_prev;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= SECRET_J1;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    store_s1    = 1'b0;
    store_s2    = 1'b0;
    do_score    = 1'b0;
    do_clear    = 1'b0;
    set_winner  = 1'b0;
    winner_next = WIN_NONE;
    err_next    = 1'b0;
    if (tick) begin
      case (state)
        SECRET_J1: begin
          if (sc_valid) begin
            store_s1   = 1'b1;
            next_state = SECRET_J2;
          end else err_next = 1'b1;
        end
        SECRET_J2: begin
          if (sc_valid) begin
            store_s2   = 1'b1;
            next_state = GUESS_J1;
          end else err_next = 1'b1;
        end
        GUESS_J1, GUESS_J2: begin
          if (sc_valid) begin
            do_score = 1'b1;
            if (sc_bulls == FULL) begin
              next_state  = WIN;
              set_winner  = 1'b1;
              winner_next = (state == GUESS_J1) ? WIN_J1 : WIN_J2;
            end else begin
              next_state = (state == GUESS_J1) ? RESULT_J1 : RESULT_J2;
            end
          end else err_next = 1'b1;
        end
        RESULT_J1: next_state = GUESS_J2;
        RESULT_J2: begin
          if (tries_j2 == MAX_T) begin
            next_state  = DRAW;
            set_winner  = 1'b1;
            winner_next = WIN_DRAW;
          end else next_state = GUESS_J1;
        end
        WIN, DRAW: begin
          do_clear   = 1'b1;
          next_state = SECRET_J1;
        end
        default: next_state = SECRET_J1;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      secret_1 <= '0;
      secret_2 <= '0;
      bulls    <= '0;
      cows     <= '0;
      tries_j1 <= '0;
      tries_j2 <= '0;
      winner   <= WIN_NONE;
      err      <= 1'b0;
    end else begin
      err <= err_next;
      if (do_clear) begin
        secret_1 <= '0;
        secret_2 <= '0;
        bulls    <= '0;
        cows     <= '0;
        tries_j1 <= '0;
        tries_j2 <= '0;
        winner   <= WIN_NONE;
      end else begin
        if (store_s1) secret_1 <= sw;
        if (store_s2) secret_2 <= sw;
        if (do_score) begin
          bulls <= sc_bulls;
          cows  <= sc_cows;
          if (state == GUESS_J1) tries_j1 <= tries_j1 + 4'd1;
          else                   tries_j2 <= tries_j2 + 4'd1;
        end
        if (set_winner) winner <= winner_next;
      end
    end
  end

  always_comb begin
    disp_next = TXT_BLANK;
    case (state)
      SECRET_J1: disp_next = TXT_SECRET_J1;
      SECRET_J2: disp_next = TXT_SECRET_J2;
      GUESS_J1:  disp_next = TXT_GUESS_J1;
      GUESS_J2:  disp_next = TXT_GUESS_J2;
      RESULT_J1: begin
        disp_next        = TXT_RESULT_J1;
        disp_next[5:0]   = num_char({1'b0, bulls});
        disp_next[29:24] = num_char({1'b0, cows});
        disp_next[47:42] = num_char(tries_j1);
      end
      RESULT_J2: begin
        disp_next        = TXT_RESULT_J2;
        disp_next[5:0]   = num_char({1'b0, bulls});
        disp_next[29:24] = num_char({1'b0, cows});
        disp_next[47:42] = num_char(tries_j2);
      end
      WIN: begin
        disp_next        = TXT_WIN;
        disp_next[47:42] = num_char({2'b00, winner});
      end
      DRAW:    disp_next = TXT_DRAW;
      default: disp_next = TXT_BLANK;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) disp <= {8{blank_char()}};
    else       disp <= disp_next;
  end

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Directed self-checking bench for bulls_cows_engine (MAX_TRIES reduced to 2).
module tb_bulls_cows_engine;
  import bc_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        confirm;
  logic [15:0] sw;
  logic [47:0] disp;
  logic [2:0]  bulls;
  logic [2:0]  cows;
  logic [3:0]  tries_j1;
  logic [3:0]  tries_j2;
  logic [1:0]  winner;
  logic        err;

  int checks = 0;
  int passes = 0;

  bulls_cows_engine #(
    .DIGITS   (4),
    .DIGIT_MAX(9),
    .MAX_TRIES(2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .confirm (confirm),
    .sw      (sw),
    .disp    (disp),
    .bulls   (bulls),
    .cows    (cows),
    .tries_j1(tries_j1),
    .tries_j2(tries_j2),
    .winner  (winner),
    .err     (err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [47:0] actual, input logic [47:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  // Entered at a negedge with confirm low; returns just after the acting edge.
  task automatic applyStimulus(input logic [15:0] value);
    sw = value;
    @(negedge clock);
    confirm = 1'b1;
    repeat (2) @(negedge clock);
    confirm = 1'b0;
  endtask

  task automatic checkState(input string tag, input state_t expected);
    checkOutput(tag, 48'(dut.state), 48'(expected));
  endtask

  logic [47:0] exp_disp;
  int          transitions;
  state_t      prev_state;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    confirm = 1'b0;
    sw      = 16'h0000;
    repeat (2) @(negedge clock);
    checkState("reset_state", SECRET_J1);
    checkOutput("reset_disp", disp, {8{6'b100000}});
    checkOutput("reset_counts", 48'({bulls, cows, tries_j1, tries_j2, winner, err}), 48'd0);

    reset = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("disp_secret_j1", disp, TXT_SECRET_J1);

    // Rejected secrets: duplicate digit and out-of-range digit.
    applyStimulus(16'h1123);
    checkOutput("err_dup", 48'(err), 48'd1);
    checkState("state_dup", SECRET_J1);
    checkOutput("secret_dup", 48'(dut.secret_1), 48'd0);
    @(negedge clock);
    checkOutput("err_one_cycle", 48'(err), 48'd0);
    applyStimulus(16'h12A4);
    checkOutput("err_range", 48'(err), 48'd1);
    checkState("state_range", SECRET_J1);
    checkOutput("secret_range", 48'(dut.secret_1), 48'd0);

    applyStimulus(16'h1234);
    checkOutput("err_valid", 48'(err), 48'd0);
    checkState("state_secret2", SECRET_J2);
    checkOutput("secret_1", 48'(dut.secret_1), 48'h1234);
    applyStimulus(16'h5678);
    checkState("state_guess1", GUESS_J1);

    applyStimulus(16'h5687);
    checkOutput("j1_bulls", 48'(bulls), 48'd2);
    checkOutput("j1_cows", 48'(cows), 48'd2);
    checkOutput("j1_tries", 48'(tries_j1), 48'd1);
    checkState("state_result1", RESULT_J1);
    @(negedge clock);
    exp_disp        = TXT_RESULT_J1;
    exp_disp[5:0]   = 6'b000100;
    exp_disp[29:24] = 6'b000100;
    exp_disp[47:42] = 6'b000010;
    checkOutput("disp_result1", disp, exp_disp);

    applyStimulus(16'h0000);
    checkState("state_guess2", GUESS_J2);
    applyStimulus(16'h1234);
    checkOutput("j2_bulls", 48'(bulls), 48'd4);
    checkOutput("j2_winner", 48'(winner), 48'd2);
    checkOutput("j2_tries", 48'(tries_j2), 48'd1);
    checkState("state_win", WIN);
    @(negedge clock);
    exp_disp        = TXT_WIN;
    exp_disp[47:42] = 6'b000100;
    checkOutput("disp_win", disp, exp_disp);

    applyStimulus(16'h0000);
    checkState("state_after_win", SECRET_J1);
    checkOutput("cleared_after_win", 48'({bulls, cows, tries_j1, tries_j2, winner}), 48'd0);
    checkOutput("secret_cleared", 48'(dut.secret_1), 48'd0);

    // Draw game: nobody ever guesses all four digits.
    applyStimulus(16'h1234);
    applyStimulus(16'h5678);
    applyStimulus(16'h1234);
    checkOutput("d1_j1", 48'({bulls, cows}), 48'({3'd0, 3'd0}));
    applyStimulus(16'h0000);
    applyStimulus(16'h5678);
    checkOutput("d1_j2", 48'({bulls, cows}), 48'({3'd0, 3'd0}));
    applyStimulus(16'h0000);
    checkState("d1_back_to_j1", GUESS_J1);
    applyStimulus(16'h8765);
    checkOutput("d2_j1", 48'({bulls, cows}), 48'({3'd0, 3'd4}));
    applyStimulus(16'h0000);
    applyStimulus(16'h1243);
    checkOutput("d2_j2", 48'({bulls, cows}), 48'({3'd2, 3'd2}));
    checkOutput("d2_tries", 48'({tries_j1, tries_j2}), 48'({4'd2, 4'd2}));
    checkState("d2_result2", RESULT_J2);
    applyStimulus(16'h0000);
    checkState("state_draw", DRAW);
    checkOutput("winner_draw", 48'(winner), 48'd3);
    @(negedge clock);
    checkOutput("disp_draw", disp, TXT_DRAW);
    applyStimulus(16'h0000);
    checkState("state_after_draw", SECRET_J1);
    checkOutput("tries_after_draw", 48'({tries_j1, tries_j2, winner}), 48'd0);

    // Holding confirm for 50 cycles must produce a single transition.
    sw          = 16'h1234;
    @(negedge clock);
    confirm     = 1'b1;
    transitions = 0;
    prev_state  = dut.state;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (dut.state != prev_state) transitions++;
      prev_state = dut.state;
    end
    confirm = 1'b0;
    checkOutput("hold_transitions", 48'(transitions), 48'd1);
    checkState("hold_state", SECRET_J2);

    applyStimulus(16'h5678);
    applyStimulus(16'h8765);
    applyStimulus(16'h0000);
    checkState("pre_reset_guess2", GUESS_J2);

    // Reset in GUESS_J2 with the button held through release.
    confirm = 1'b1;
    reset   = 1'b1;
    @(negedge clock);
    checkState("midreset_state", SECRET_J1);
    checkOutput("midreset_counts", 48'({bulls, cows, tries_j1, tries_j2, winner, err}), 48'd0);
    checkOutput("midreset_disp", disp, {8{6'b100000}});
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checkState("no_tick_after_reset", SECRET_J1);
    checkOutput("secret_after_reset", 48'(dut.secret_1), 48'd0);
    confirm = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bulls_cows_engine.md
BULLS_COWS_ENGINE -- requirements
Module: bulls_cows_engine

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of code digits (legal range 2..4).
REQ-002 SHALL have parameter DIGIT_MAX, default 9, meaning the highest legal digit value (range 1..15).
REQ-003 SHALL have parameter MAX_TRIES, default 10, meaning guesses allowed per player before a draw (range 1..15).
REQ-004 SHALL have port clock  input  1  system clock.
REQ-005 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port confirm  input  1  synchronous button level, edge-detected internally.
REQ-007 SHALL have port sw  input  DIGITS*4  code entry, digit k at sw[4k+3:4k].
REQ-008 SHALL have port disp  output  48  eight 6-bit character codes, char c at disp[6c+5:6c].
REQ-009 SHALL have port bulls  output  3  bull count of the last scored guess.
REQ-010 SHALL have port cows  output  3  cow count of the last scored guess.
REQ-011 SHALL have port tries_j1 and tries_j2  output  4 each  valid guesses made per player.
REQ-012 SHALL have port winner  output  2  0 none, 1 J1, 2 J2, 3 draw.
REQ-013 SHALL have port err  output  1  one-cycle pulse on a rejected entry.

Function
REQ-014 SHALL produce tick one cycle after confirm is sampled high following a low sample; holding confirm high SHALL yield exactly one tick.
REQ-015 SHALL treat an entry as valid only when every digit is <= DIGIT_MAX and all DIGITS digits are pairwise distinct.
REQ-016 SHALL implement states SECRET_J1, SECRET_J2, GUESS_J1, RESULT_J1, GUESS_J2, RESULT_J2, WIN, DRAW.
REQ-017 On tick in SECRET_Jn with a valid entry, SHALL store sw as secret_n and advance: SECRET_J1->SECRET_J2->GUESS_J1.
REQ-018 On tick in GUESS_Jn with a valid entry, SHALL score sw against the opponent's secret, register bulls/cows, and increment tries_jn on the same edge.
REQ-019 SHALL compute bulls as the count of positions k with guess[k]==secret[k].
REQ-020 SHALL compute cows as the count of pairs i!=j with guess[i]==secret[j].
REQ-021 After a scored guess with bulls==DIGITS, SHALL go to WIN and set winner=n; otherwise SHALL go to RESULT_Jn.
REQ-022 On tick in RESULT_J1, SHALL go to GUESS_J2.
REQ-023 On tick in RESULT_J2, SHALL go to DRAW with winner=3 if tries_j2==MAX_TRIES, else to GUESS_J1.
REQ-024 On tick in WIN or DRAW, SHALL clear secrets, tries, bulls, cows and winner, and go to SECRET_J1.
REQ-025 On tick with an invalid entry in any SECRET or GUESS state, SHALL pulse err for one cycle and change no other state.
REQ-026 SHALL register disp, updating one cycle after any state change.
REQ-027 SHALL encode a numeric character as {1'b0, value[3:0], 1'b0} and a blank as 6'b100000.
REQ-028 In RESULT states, SHALL show bulls at char0, cows at char4 and tries_jn at char7, with package text codes on the remaining chars.
REQ-029 In WIN, SHALL show the winner number at char7; all other state texts SHALL come from package constants.

Reset
REQ-030 On reset, SHALL set state=SECRET_J1, secrets=0, bulls=0, cows=0, tries=0, winner=0, err=0 and disp=all blank.
REQ-031 On reset, SHALL set the confirm edge register to 1, so that a confirm held through reset release produces no tick.
REQ-032 Reset mid-game SHALL abandon the game immediately, with no partial scoring.

Structure
REQ-033 SHALL place the state enum, character text constants, blank/numeric encoding helpers and winner codes in package bc_pkg.
REQ-034 SHALL implement scoring and validity checking in a purely combinational sub-module bc_scorer (inputs guess, secret; outputs bulls, cows, valid), parametrised by DIGITS and DIGIT_MAX.

Verification
REQ-035 SHALL verify: secrets 0x1234/0x5678, J1 guesses 0x5687 -> bulls=2, cows=2, tries_j1=1, state RESULT_J1.
REQ-036 SHALL verify: entry 0x1123 or 0x12A4 in SECRET_J1 -> err pulse, state unchanged, secret not stored.
REQ-037 SHALL verify: J2 guesses 0x1234 against secret_1=0x1234 -> bulls=4, winner=2, WIN; next tick -> SECRET_J1 with all counters cleared.
REQ-038 SHALL verify: MAX_TRIES=2 with no correct guesses -> after the second RESULT_J2 tick, winner=3 and state DRAW.
REQ-039 SHALL verify: confirm held high for 50 cycles -> exactly one tick and one transition.
REQ-040 SHALL verify: reset asserted in GUESS_J2 -> next cycle all outputs at reset values; confirm high through release -> no tick.
